// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - complementary gate-pair generator with programmable dead time and sticky fault
module pwm_deadtime #(
  parameter int NUM_CHANNELS = 4,
  parameter int DT_WIDTH     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CHANNELS-1:0]          i_en,
  input  logic [NUM_CHANNELS-1:0]          i_pwm,
  input  logic [NUM_CHANNELS*DT_WIDTH-1:0] i_dt_rise,
  input  logic [NUM_CHANNELS*DT_WIDTH-1:0] i_dt_fall,
  input  logic                             i_fault,
  input  logic                             i_fault_clr,
  output logic [NUM_CHANNELS-1:0]          o_hi,
  output logic [NUM_CHANNELS-1:0]          o_lo,
  output logic [NUM_CHANNELS-1:0]          o_dead,
  output logic                             o_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DT_LH = 3'd1,
    S_HI    = 3'd2,
    S_DT_HL = 3'd3,
    S_LO    = 3'd4
  } state_t;

  localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);

  logic [NUM_CHANNELS-1:0] pwm_q;
  logic                    fault_q;
  logic                    fault_d;
  logic                    hold;

  // Set wins over clear; hold also covers the clear cycle so channels sit one cycle in IDLE.
  assign fault_d = i_fault | (fault_q & ~i_fault_clr);
  assign hold    = i_fault | fault_q;
  assign o_fault = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      pwm_q   <= i_pwm;
      fault_q <= fault_d;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DT_WIDTH-1:0] dt_rise, dt_fall;
    logic                hi_q, lo_q, dead_q;

    assign dt_rise = i_dt_rise[g*DT_WIDTH +: DT_WIDTH];
    assign dt_fall = i_dt_fall[g*DT_WIDTH +: DT_WIDTH];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        S_IDLE: begin
          if (pwm_q[g]) begin
            state_d = S_DT_LH;
            cnt_d   = dt_rise;
          end else begin
            state_d = S_DT_HL;
            cnt_d   = dt_fall;
          end
        end
        S_DT_LH: begin
          if (!pwm_q[g])           state_d = S_LO;
          else if (cnt_q <= DT_ONE) state_d = S_HI;
          else                      cnt_d   = cnt_q - DT_ONE;
        end
        S_HI: begin
          if (!pwm_q[g]) begin
            state_d = S_DT_HL;
            cnt_d   = dt_fall;
          end
        end
        S_DT_HL: begin
          if (pwm_q[g])             state_d = S_HI;
          else if (cnt_q <= DT_ONE) state_d = S_LO;
          else                      cnt_d   = cnt_q - DT_ONE;
        end
        S_LO: begin
          if (pwm_q[g]) begin
            state_d = S_DT_LH;
            cnt_d   = dt_rise;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (hold || !i_en[g]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end

    // Gate drives are decoded from the next state so they register together with it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        hi_q    <= 1'b0;
        lo_q    <= 1'b0;
        dead_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hi_q    <= (state_d == S_HI);
        lo_q    <= (state_d == S_LO);
        dead_q  <= (state_d == S_DT_LH) || (state_d == S_DT_HL);
      end
    end

    assign o_hi[g]   = hi_q;
    assign o_lo[g]   = lo_q;
    assign o_dead[g] = dead_q;
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb/tb_pwm_deadtime.sv - directed vector bench for pwm_deadtime
module tb_pwm_deadtime;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [3:0]  pwm;
  logic [31:0] dt_rise;
  logic [31:0] dt_fall;
  logic        fault;
  logic        clr;
  logic [3:0]  o_hi, o_lo, o_dead;
  logic        o_fault;

  int total = 0;
  int bad   = 0;
  bit mon_en = 0;

  int dtr[4] = '{3, 0, 1, 6};
  int dtf[4] = '{5, 0, 2, 4};

  typedef struct {
    logic [3:0] en;
    logic [3:0] pwm;
    logic       flt_in;
    logic       clr;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] dead;
    logic       flt;
  } vec_t;

  vec_t tbl[$];

  pwm_deadtime #(.NUM_CHANNELS(4), .DT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (en),
    .i_pwm      (pwm),
    .i_dt_rise  (dt_rise),
    .i_dt_fall  (dt_fall),
    .i_fault    (fault),
    .i_fault_clr(clr),
    .o_hi       (o_hi),
    .o_lo       (o_lo),
    .o_dead     (o_dead),
    .o_fault    (o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if ((o_hi & o_lo) != 4'h0) begin
        bad++;
        $display("FAIL overlap t=%0t hi&lo=%b required=0000", $time, o_hi & o_lo);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Channel-0 vector: n identical cycles; other channels stay disabled and low.
  task automatic add(input int n, input logic e, input logic p, input logic f, input logic c,
                     input logic h, input logic l, input logic d, input logic o);
    vec_t v;
    v.en = {3'b000, e}; v.pwm = {3'b000, p}; v.flt_in = f; v.clr = c;
    v.hi = {3'b000, h}; v.lo = {3'b000, l}; v.dead = {3'b000, d}; v.flt = o;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  function automatic int mx1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Drive every channel to the other side and measure per-channel rise latency and dead length.
  task automatic edge_test(input logic to_hi);
    int lat[4];
    int dcnt[4];
    pwm = to_hi ? 4'hF : 4'h0;
    step();
    chk(to_hi ? "edge_k_lo_held" : "edge_k_hi_held", to_hi ? o_lo : o_hi, 4'hF);
    step();
    chk("edge_k1_all_dead", {o_hi, o_lo, o_dead}, {4'h0, 4'h0, 4'hF});
    for (int n = 0; n < 4; n++) begin
      lat[n] = -1;
      dcnt[n] = 1;
    end
    for (int j = 1; j <= 20; j++) begin
      step();
      for (int n = 0; n < 4; n++) begin
        if (o_dead[n]) dcnt[n]++;
        if (lat[n] < 0 && (to_hi ? o_hi[n] : o_lo[n])) lat[n] = j;
      end
    end
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("%s_latency_ch%0d", to_hi ? "rise" : "fall", n), lat[n],
          mx1(to_hi ? dtr[n] : dtf[n]));
      chk($sformatf("%s_deadlen_ch%0d", to_hi ? "rise" : "fall", n), dcnt[n],
          mx1(to_hi ? dtr[n] : dtf[n]));
    end
  endtask

  initial begin
    rst = 1'b1; en = 4'h0; pwm = 4'h0; fault = 1'b0; clr = 1'b0;
    for (int n = 0; n < 4; n++) begin
      dt_rise[n*8 +: 8] = dtr[n][7:0];
      dt_fall[n*8 +: 8] = dtf[n][7:0];
    end
    step();
    step();
    chk("reset_hi", o_hi, 4'h0);
    chk("reset_lo", o_lo, 4'h0);
    chk("reset_dead", o_dead, 4'h0);
    chk("reset_fault", o_fault, 1'b0);
    rst = 1'b0;
    mon_en = 1;

    //   n  en pwm f  c   hi lo dd flt
    add(5,  1, 0,  0, 0,  0, 0, 1, 0);  // enable -> DT_HL for dt_fall=5
    add(1,  1, 0,  0, 0,  0, 1, 0, 0);
    add(1,  1, 1,  0, 0,  0, 1, 0, 0);  // pwm_q updates, lo held
    add(3,  1, 1,  0, 0,  0, 0, 1, 0);  // dt_rise=3
    add(1,  1, 1,  0, 0,  1, 0, 0, 0);
    add(1,  1, 0,  0, 0,  1, 0, 0, 0);
    add(5,  1, 0,  0, 0,  0, 0, 1, 0);  // dt_fall=5
    add(1,  1, 0,  0, 0,  0, 1, 0, 0);
    add(1,  1, 1,  0, 0,  0, 1, 0, 0);  // 2-cycle glitch
    add(1,  1, 1,  0, 0,  0, 0, 1, 0);
    add(1,  1, 0,  0, 0,  0, 0, 1, 0);
    add(2,  1, 0,  0, 0,  0, 1, 0, 0);  // aborted back to LO
    add(1,  1, 1,  0, 0,  0, 1, 0, 0);
    add(1,  1, 1,  0, 0,  0, 0, 1, 0);
    add(2,  0, 1,  0, 0,  0, 0, 0, 0);  // disable mid DT_LH
    add(3,  1, 1,  0, 0,  0, 0, 1, 0);
    add(2,  1, 1,  0, 0,  1, 0, 0, 0);
    add(1,  1, 1,  1, 0,  0, 0, 0, 1);  // fault in HI
    add(1,  1, 1,  1, 1,  0, 0, 0, 1);  // clear while fault high ignored
    add(1,  1, 1,  0, 0,  0, 0, 0, 1);
    add(1,  1, 1,  0, 1,  0, 0, 0, 0);  // cleared, still IDLE one cycle
    add(3,  1, 1,  0, 0,  0, 0, 1, 0);
    add(1,  1, 1,  0, 0,  1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; pwm = tbl[i].pwm; fault = tbl[i].flt_in; clr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_hi_lo_dead_flt", i), {o_hi, o_lo, o_dead, o_fault},
          {tbl[i].hi, tbl[i].lo, tbl[i].dead, tbl[i].flt});
    end
    fault = 1'b0; clr = 1'b0;

    en = 4'hF; pwm = 4'h0;
    for (int j = 0; j < 12; j++) step();
    chk("all_settled_lo", {o_hi, o_lo, o_dead}, {4'h0, 4'hF, 4'h0});
    edge_test(1'b1);

    fault = 1'b1;
    step();
    chk("fault_from_hi", {o_hi, o_lo, o_dead, o_fault}, {4'h0, 4'h0, 4'h0, 1'b1});
    fault = 1'b0; clr = 1'b1;
    step();
    chk("fault_clear_idle", {o_hi, o_lo, o_dead, o_fault}, {4'h0, 4'h0, 4'h0, 1'b0});
    clr = 1'b0;
    step();
    chk("fault_reentry_dead", {o_hi, o_lo, o_dead}, {4'h0, 4'h0, 4'hF});
    for (int j = 0; j < 8; j++) step();
    chk("fault_recovered_hi", {o_hi, o_lo}, {4'hF, 4'h0});
    edge_test(1'b0);

    pwm = 4'hF;
    step();
    step();
    chk("pre_reset_dead", o_dead, 4'hF);
    #3 rst = 1'b1;
    #1 chk("async_reset_outputs", {o_hi, o_lo, o_dead, o_fault}, 13'h0);
    #2 rst = 1'b0;
    #1 chk("post_reset_idle", {o_hi, o_lo, o_dead}, 12'h0);
    step();
    chk("post_reset_reentry", {o_hi, o_lo, o_dead}, {4'h0, 4'h0, 4'hF});

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
# pwm_deadtime

Complementary-output dead-time generator that sits directly downstream of the multi-channel PWM timer. It consumes one raw PWM bit per channel and drives a high-side/low-side gate pair per channel. Programmable rising and falling dead times guarantee the two sides of a pair are never asserted together. A sticky, global fault input forces every gate low until software clears it.

## Interface
- NUM_CHANNELS, 4, number of PWM channels / gate pairs
- DT_WIDTH, 8, width of each dead-time value in clk cycles
- clk  in  1  clock, the same clock that drives the PWM generator outputs
- rst  in  1  reset, asynchronous, active-high
- i_en  in  NUM_CHANNELS  per-channel enable; 0 forces the channel to IDLE
- i_pwm  in  NUM_CHANNELS  raw PWM from the timer, bit n = channel n
- i_dt_rise  in  NUM_CHANNELS*DT_WIDTH  dead time before high side turns on; slice [n*DT_WIDTH +: DT_WIDTH]
- i_dt_fall  in  NUM_CHANNELS*DT_WIDTH  dead time before low side turns on; same slicing
- i_fault  in  1  synchronous fault request, active-high
- i_fault_clr  in  1  single-cycle fault-clear strobe
- o_hi  out  NUM_CHANNELS  high-side gate drive, registered
- o_lo  out  NUM_CHANNELS  low-side gate drive, registered
- o_dead  out  NUM_CHANNELS  1 while the channel is in a dead-time state
- o_fault  out  1  fault latched

## Operation
- i_pwm is registered once into pwm_q. No synchronizer is used, because the input is already in the clk domain.
- Each channel has an independent FSM with states IDLE, DT_LH, HI, DT_HL, LO. There is also one global fault latch.
- Output decode, registered together with the state:
  - HI: hi=1, lo=0
  - LO: hi=0, lo=1
  - IDLE, DT_LH, DT_HL, or fault latched: hi=0, lo=0
  - o_dead=1 only in DT_LH and DT_HL.
- IDLE:
  - i_en=1 and pwm_q=1: go to DT_LH, loading cnt with dt_rise.
  - i_en=1 and pwm_q=0: go to DT_HL, loading cnt with dt_fall.
  - Enabling a channel therefore always passes through a dead interval.
- DT_LH:
  - pwm_q=0: go to LO immediately (abort; the high side was never on).
  - Otherwise, cnt<=1: go to HI.
  - Otherwise: cnt decrements.
- HI: pwm_q=0 → DT_HL, loading cnt with dt_fall.
- DT_HL, symmetric to DT_LH:
  - pwm_q=1: go to HI immediately.
  - Otherwise, cnt<=1: go to LO.
  - Otherwise: cnt decrements.
- LO: pwm_q=1 → DT_LH, loading cnt with dt_rise.
- Dead-time value rules:
  - The value is sampled only on entry to a DT state; changes during the count are ignored.
  - The dead interval lasts max(dt,1) cycles, so dt=0 still gives 1 cycle with both sides low.
- i_en=0 in any state: go to IDLE on the next edge.
- Fault latch:
  - Sets on i_fault=1.
  - Clears on i_fault_clr=1 only when i_fault=0. Set wins if both are asserted in the same cycle.
  - While latched, all channels are held in IDLE with all outputs low.
  - After clear, enabled channels re-enter through a DT state.
- Invariant: o_hi[n] & o_lo[n] is never 1 in any cycle, including reset, enable changes, and fault entry/exit.

## Timing
- Reset values: all o_hi=0, o_lo=0, o_dead=0, o_fault=0. State is IDLE, cnt=0, pwm_q=0.
- Edge latency, with i_pwm changing before edge k:
  - pwm_q updates at edge k.
  - The outgoing side falls and o_dead rises at edge k+1.
  - The incoming side rises at edge k+1+max(dt,1).
- Fault latency: i_fault=1 before edge k gives o_fault=1 and all gates low at edge k.
- Fault clear: i_fault_clr before edge k gives o_fault=0 at edge k. A channel then takes 1 cycle in IDLE and at least 1 dead cycle before any gate rises.
- Short pulses: a PWM pulse of width ≤ dt is swallowed, and the gates return to the prior side with no high-side pulse.
- Reset mid-count drops all gates low asynchronously, immediately.

## Test plan
- **Basic dead time:** dt_rise=3, dt_fall=5, i_en=1, i_pwm square wave of 20 cycles per half-period. Check:
  - o_lo falls at edge k+1 and o_hi rises 3 cycles later.
  - o_hi falls, then o_lo rises 5 cycles later.
  - hi&lo is never 1.
- **Zero dead time:** dt=0 → exactly 1 dead cycle per transition; o_dead is a 1-cycle pulse.
- **Glitch abort:** dt_rise=6, 2-cycle i_pwm high pulse while in LO → o_hi stays 0, o_lo returns 1, and o_dead lasts 2 cycles.
- **Fault:** i_fault asserted while channel 2 is in HI → all gates 0 and o_fault=1 at the next edge. Then:
  - i_fault_clr with i_fault still high → remains latched.
  - Drop i_fault, then clear → channels re-enter through DT_LH/DT_HL.
- **Enable and reset:** i_en toggled 1→0 mid-DT_LH → IDLE with all outputs 0 at the next edge. Asserting rst mid-count → all outputs 0 immediately and the FSM is in IDLE after release.
- **Channel independence:** 4 channels with different dt values and phases → each channel's timing matches its own slice, with no cross-channel interference.
